// File: rtl/nano_pkg.sv
// -----------------------------------------------------------------------------
// nano_pkg
// Shared definitions for the 8-bit nano processor. The control unit, the
// instruction decoder and the ULA all import this package:
//   - opcode values of the 16-bit instruction word
//   - ULA operation codes (the ULA decodes these same values)
//   - control FSM state encoding
//   - instruction field bit positions, plus small field-extraction helpers
// -----------------------------------------------------------------------------
package nano_pkg;

  // Opcodes, instruction bits [15:12]. Values 10..14 are undefined and run as NOP.
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_LDI  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_BZ   = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  // ULA operation codes.
  localparam logic [2:0] ULA_ADD    = 3'd0;
  localparam logic [2:0] ULA_SUB    = 3'd1;
  localparam logic [2:0] ULA_AND    = 3'd2;
  localparam logic [2:0] ULA_OR     = 3'd3;
  localparam logic [2:0] ULA_XOR    = 3'd4;
  localparam logic [2:0] ULA_PASS_A = 3'd5;

  // Control FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  // Instruction field positions. imm overlaps rs1/rs2; which one is meaningful
  // depends on the opcode.
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  function automatic logic [3:0] f_opcode(input logic [15:0] instr);
    return instr[OPC_LSB +: 4];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] instr);
    return instr[RD_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rs1(input logic [15:0] instr);
    return instr[RS1_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rs2(input logic [15:0] instr);
    return instr[RS2_LSB +: 3];
  endfunction

  function automatic logic [7:0] f_imm(input logic [15:0] instr);
    return instr[IMM_LSB +: 8];
  endfunction

endpackage

// File: rtl/decodificador_instr.sv
// -----------------------------------------------------------------------------
// decodificador_instr
// Purely combinational opcode decoder for the nano processor control unit.
// Ports:
//   opcode    in  4  instruction opcode field
//   ula_op    out 3  ULA operation for ALU/MOV instructions, ULA_ADD otherwise
//   is_alu    out 1  ADD/SUB/AND/OR/XOR/MOV (register result through the ULA)
//   is_ldi    out 1  load immediate
//   is_jmp    out 1  unconditional jump
//   is_bz     out 1  branch if register is zero
//   is_halt   out 1  halt
//   writes_rd out 1  instruction writes the destination register
// -----------------------------------------------------------------------------
module decodificador_instr
  import nano_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] ula_op,
  output logic       is_alu,
  output logic       is_ldi,
  output logic       is_jmp,
  output logic       is_bz,
  output logic       is_halt,
  output logic       writes_rd
);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path leaves
    // a variable unassigned, which would infer a latch.
    ula_op  = ULA_ADD;
    is_alu  = 1'b0;
    is_ldi  = 1'b0;
    is_jmp  = 1'b0;
    is_bz   = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_ADD:  begin is_alu = 1'b1; ula_op = ULA_ADD;    end
      OP_SUB:  begin is_alu = 1'b1; ula_op = ULA_SUB;    end
      OP_AND:  begin is_alu = 1'b1; ula_op = ULA_AND;    end
      OP_OR:   begin is_alu = 1'b1; ula_op = ULA_OR;     end
      OP_XOR:  begin is_alu = 1'b1; ula_op = ULA_XOR;    end
      OP_MOV:  begin is_alu = 1'b1; ula_op = ULA_PASS_A; end
      OP_LDI:  is_ldi  = 1'b1;
      OP_JMP:  is_jmp  = 1'b1;
      OP_BZ:   is_bz   = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ; // NOP and undefined opcodes
    endcase
    writes_rd = is_alu | is_ldi;
  end

endmodule

// File: rtl/controle_execucao.sv
// -----------------------------------------------------------------------------
// controle_execucao
// Multi-cycle control unit of the 8-bit nano processor. Each instruction walks
// FETCH -> DECODE -> [EXEC] -> [WB] so the register bank's registered read
// latency is honoured and a write always lands before the next read samples.
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   start        in  1   begin from IDLE / restart from HALTED (ignored if busy)
//   instr_addr   out PC_W ROM address (the program counter)
//   instr_data   in  16  ROM data, one cycle after instr_addr
//   add_r1/add_r2 out 3  bank read addresses
//   dado_r1/dado_r2 in 8 bank read data (registered in the bank)
//   wr_en/add_wr/dado_wr bank write port
//   ula_op       out 3   ULA operation
//   ula_res      in  8   ULA result of dado_r1 op dado_r2
//   busy         out 1   executing (FETCH/DECODE/EXEC/WB)
//   halted       out 1   stopped on HALT
// -----------------------------------------------------------------------------
module controle_execucao
  import nano_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  output logic [2:0]      add_r1,
  output logic [2:0]      add_r2,
  input  logic [7:0]      dado_r1,
  input  logic [7:0]      dado_r2,
  output logic            wr_en,
  output logic [2:0]      add_wr,
  output logic [7:0]      dado_wr,
  output logic [2:0]      ula_op,
  input  logic [7:0]      ula_res,
  output logic            busy,
  output logic            halted
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      res_q, res_d;

  // In DECODE the word is still on the ROM bus; afterwards it lives in IR.
  // One decoder serves both phases through this mux.
  logic [15:0] word;
  logic [2:0]  dec_ula_op;
  logic        dec_is_alu, dec_is_ldi, dec_is_jmp, dec_is_bz, dec_is_halt;
  logic        dec_writes_rd;
  logic [7:0]  imm;

  assign word = (state_q == ST_DECODE) ? instr_data : ir_q;
  assign imm  = f_imm(word);

  decodificador_instr u_dec (
    .opcode    (f_opcode(word)),
    .ula_op    (dec_ula_op),
    .is_alu    (dec_is_alu),
    .is_ldi    (dec_is_ldi),
    .is_jmp    (dec_is_jmp),
    .is_bz     (dec_is_bz),
    .is_halt   (dec_is_halt),
    .writes_rd (dec_writes_rd)
  );

  // Operand B goes straight from the bank to the ULA; control never inspects it.
  logic unused_dado_r2;
  assign unused_dado_r2 = ^dado_r2;

  assign instr_addr = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      res_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    add_r1  = '0;
    add_r2  = '0;
    wr_en   = 1'b0;
    add_wr  = '0;
    dado_wr = '0;
    ula_op  = '0;
    busy    = 1'b0;
    halted  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        busy    = 1'b1;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        busy = 1'b1;
        ir_d = instr_data;
        // Present read addresses now so the bank's registered outputs are
        // valid in EXEC. BZ tests the register named in the rd field.
        add_r1 = dec_is_bz ? f_rd(word) : f_rs1(word);
        add_r2 = f_rs2(word);
        if (dec_is_jmp)       pc_d = imm[PC_W-1:0];
        else if (!dec_is_halt) pc_d = pc_q + 1'b1;
        if (dec_is_alu || dec_is_bz) state_d = ST_EXEC;
        else if (dec_is_ldi)         state_d = ST_WB;
        else if (dec_is_halt)        state_d = ST_HALTED;
        else                         state_d = ST_FETCH;
      end

      ST_EXEC: begin
        busy   = 1'b1;
        add_r1 = dec_is_bz ? f_rd(word) : f_rs1(word);
        add_r2 = f_rs2(word);
        ula_op = dec_ula_op;
        if (dec_is_bz) begin
          if (dado_r1 == 8'h00) pc_d = imm[PC_W-1:0];
          state_d = ST_FETCH;
        end else begin
          res_d   = ula_res;
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        busy    = 1'b1;
        wr_en   = dec_writes_rd;
        add_wr  = f_rd(word);
        dado_wr = dec_is_ldi ? imm : res_q;
        state_d = ST_FETCH;
      end

      ST_HALTED: begin
        halted = 1'b1;
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_controle_execucao.sv
module tb_controle_execucao;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] instr_addr;
  logic [15:0]     instr_data;
  logic [2:0]      add_r1, add_r2, add_wr, ula_op;
  logic [7:0]      dado_r1, dado_r2, dado_wr, ula_res;
  logic            wr_en, busy, halted;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  controle_execucao #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .add_r1     (add_r1),
    .add_r2     (add_r2),
    .dado_r1    (dado_r1),
    .dado_r2    (dado_r2),
    .wr_en      (wr_en),
    .add_wr     (add_wr),
    .dado_wr    (dado_wr),
    .ula_op     (ula_op),
    .ula_res    (ula_res),
    .busy       (busy),
    .halted     (halted)
  );

  // ---------------- environment: ROM, register bank, ULA ----------------
  logic [15:0] rom [0:255];
  logic [7:0]  bank [0:7];

  always @(posedge clk) instr_data <= rom[instr_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'hF0 + 8'(i);
      dado_r1 <= 8'h00;
      dado_r2 <= 8'h00;
    end else begin
      if (wr_en) bank[add_wr] <= dado_wr;
      dado_r1 <= bank[add_r1];
      dado_r2 <= bank[add_r2];
    end
  end

  always_comb begin
    ula_res = 8'h00;
    case (ula_op)
      3'd0: ula_res = dado_r1 + dado_r2;
      3'd1: ula_res = dado_r1 - dado_r2;
      3'd2: ula_res = dado_r1 & dado_r2;
      3'd3: ula_res = dado_r1 | dado_r2;
      3'd4: ula_res = dado_r1 ^ dado_r2;
      3'd5: ula_res = dado_r1;
      default: ula_res = 8'h00;
    endcase
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Snapshot of every DUT output, one per clock cycle.
  typedef struct packed {
    logic       busy;
    logic       halted;
    logic       wr_en;
    logic [2:0] add_wr;
    logic [7:0] dado_wr;
    logic [7:0] instr_addr;
    logic [2:0] ula_op;
    logic [2:0] add_r1;
    logic [2:0] add_r2;
  } cyc_t;

  function automatic cyc_t mk(input logic b, input logic h, input logic we,
                              input logic [2:0] wa, input logic [7:0] wd,
                              input logic [7:0] ia, input logic [2:0] uo,
                              input logic [2:0] r1, input logic [2:0] r2);
    cyc_t c;
    c.busy = b; c.halted = h; c.wr_en = we; c.add_wr = wa; c.dado_wr = wd;
    c.instr_addr = ia; c.ula_op = uo; c.add_r1 = r1; c.add_r2 = r2;
    return c;
  endfunction

  function automatic cyc_t sample();
    return mk(busy, halted, wr_en, add_wr, dado_wr, instr_addr, ula_op, add_r1, add_r2);
  endfunction

  // Instruction-level reference model: runs the program from pc=0 with the
  // bank at reset contents and expands each instruction into its per-cycle
  // output pattern using the documented latencies.
  cyc_t exp_q[$];

  task automatic build_trace(input int n_cycles);
    logic [7:0] pc, npc, a, b, r, imm;
    logic [7:0] regs [0:7];
    logic [15:0] ins;
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    bit stopped;
    exp_q.delete();
    for (int i = 0; i < 8; i++) regs[i] = 8'hF0 + 8'(i);
    pc = 8'h00;
    stopped = 0;
    while (exp_q.size() < n_cycles) begin
      if (stopped) begin
        exp_q.push_back(mk(0, 1, 0, 0, 0, pc, 0, 0, 0));
        continue;
      end
      ins = rom[pc];
      op  = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3]; imm = ins[7:0];
      npc = pc + 8'd1;
      exp_q.push_back(mk(1, 0, 0, 0, 0, pc, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, pc, 0, (op == 4'd9) ? rd : rs1, rs2));
      if (op >= 4'd1 && op <= 4'd6) begin
        a = regs[rs1]; b = regs[rs2];
        case (op)
          4'd1: r = a + b;
          4'd2: r = a - b;
          4'd3: r = a & b;
          4'd4: r = a | b;
          4'd5: r = a ^ b;
          default: r = a;
        endcase
        exp_q.push_back(mk(1, 0, 0, 0, 0, npc, 3'(op - 4'd1), rs1, rs2));
        exp_q.push_back(mk(1, 0, 1, rd, r, npc, 0, 0, 0));
        regs[rd] = r;
        pc = npc;
      end else if (op == 4'd7) begin
        exp_q.push_back(mk(1, 0, 1, rd, imm, npc, 0, 0, 0));
        regs[rd] = imm;
        pc = npc;
      end else if (op == 4'd8) begin
        pc = imm;
      end else if (op == 4'd9) begin
        exp_q.push_back(mk(1, 0, 0, 0, 0, npc, 0, rd, rs2));
        pc = (regs[rd] == 8'h00) ? imm : npc;
      end else if (op == 4'd15) begin
        stopped = 1;
      end else begin
        pc = npc;
      end
    end
  endtask

  // ---------------- sequencing helpers ----------------
  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic leave_reset_and_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;   // DUT now in its first FETCH
  endtask

  typedef struct {
    logic [15:0] instr;
    int          lat;
    bit          writes;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  next_addr;
    bit          halts;
    logic [2:0]  uop;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int nw;
    logic [2:0] cap_wa, cap_uop;
    logic [7:0] cap_wd;
    cyc_t act;

    vecs[0]  = '{16'h1050, 4, 1'b1, 3'd0, 8'hE3, 8'h01, 1'b0, 3'd0}; // ADD r0,r1,r2
    vecs[1]  = '{16'h2838, 4, 1'b1, 3'd4, 8'hF9, 8'h01, 1'b0, 3'd1}; // SUB r4,r0,r7
    vecs[2]  = '{16'h3AE0, 4, 1'b1, 3'd5, 8'hF0, 8'h01, 1'b0, 3'd2}; // AND r5,r3,r4
    vecs[3]  = '{16'h4C50, 4, 1'b1, 3'd6, 8'hF3, 8'h01, 1'b0, 3'd3}; // OR  r6,r1,r2
    vecs[4]  = '{16'h5E50, 4, 1'b1, 3'd7, 8'h03, 8'h01, 1'b0, 3'd4}; // XOR r7,r1,r2
    vecs[5]  = '{16'h6540, 4, 1'b1, 3'd2, 8'hF5, 8'h01, 1'b0, 3'd5}; // MOV r2,r5
    vecs[6]  = '{16'h765A, 3, 1'b1, 3'd3, 8'h5A, 8'h01, 1'b0, 3'd0}; // LDI r3,5A
    vecs[7]  = '{16'h8005, 2, 1'b0, 3'd0, 8'h00, 8'h05, 1'b0, 3'd0}; // JMP 5
    vecs[8]  = '{16'h9610, 3, 1'b0, 3'd0, 8'h00, 8'h01, 1'b0, 3'd0}; // BZ r3 (F3), not taken
    vecs[9]  = '{16'h0000, 2, 1'b0, 3'd0, 8'h00, 8'h01, 1'b0, 3'd0}; // NOP
    vecs[10] = '{16'hA000, 2, 1'b0, 3'd0, 8'h00, 8'h01, 1'b0, 3'd0}; // undefined = NOP
    vecs[11] = '{16'hE123, 2, 1'b0, 3'd0, 8'h00, 8'h01, 1'b0, 3'd0}; // undefined = NOP
    vecs[12] = '{16'hF000, 2, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd0}; // HALT

    // Reset state: every output low.
    enter_reset();
    #1;
    check("reset outputs", 64'(sample()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));

    // ---- table-driven single-instruction vectors ----
    for (int v = 0; v < 13; v++) begin
      enter_reset();
      rom[0] = vecs[v].instr;
      rom[1] = 16'h0000;
      rom[5] = 16'h0000;
      leave_reset_and_start();
      nw = 0; cap_wa = '0; cap_wd = '0; cap_uop = '0;
      for (int c = 0; c < vecs[v].lat; c++) begin
        if (wr_en) begin nw++; cap_wa = add_wr; cap_wd = dado_wr; end
        if (c == 2) cap_uop = ula_op;
        @(negedge clk);
      end
      check($sformatf("v%0d next instr_addr", v), 64'(instr_addr), 64'(vecs[v].next_addr));
      check($sformatf("v%0d busy/halted", v), 64'({busy, halted}),
            64'({!vecs[v].halts, vecs[v].halts}));
      check($sformatf("v%0d write count", v), 64'(nw), 64'(vecs[v].writes ? 1 : 0));
      if (vecs[v].writes) begin
        check($sformatf("v%0d add_wr", v), 64'(cap_wa), 64'(vecs[v].wa));
        check($sformatf("v%0d dado_wr", v), 64'(cap_wd), 64'(vecs[v].wd));
      end
      if (vecs[v].lat == 4)
        check($sformatf("v%0d ula_op in EXEC", v), 64'(cap_uop), 64'(vecs[v].uop));
    end

    // ---- LDI r3 then BZ r3: taken (imm 0) and not taken (imm 7) ----
    for (int k = 0; k < 2; k++) begin
      enter_reset();
      rom[0] = (k == 0) ? 16'h7600 : 16'h7607;
      rom[1] = 16'h9610;
      rom[2] = 16'h0000;
      rom[16] = 16'h0000;
      leave_reset_and_start();
      nw = 0;
      for (int c = 0; c < 6; c++) begin
        if (wr_en) begin nw++; cap_wa = add_wr; cap_wd = dado_wr; end
        @(negedge clk);
      end
      check($sformatf("ldi/bz%0d write", k), 64'({nw[3:0], cap_wa, cap_wd}),
            64'({4'd1, 3'd3, (k == 0) ? 8'h00 : 8'h07}));
      check($sformatf("ldi/bz%0d next instr_addr", k), 64'(instr_addr),
            64'((k == 0) ? 8'h10 : 8'h02));
      check($sformatf("ldi/bz%0d busy", k), 64'(busy), 64'(1));
    end

    // ---- JMP 5 -> HALT, hold, restart ----
    enter_reset();
    rom[0] = 16'h8005;
    rom[5] = 16'hF000;
    leave_reset_and_start();
    check("jmp cycle0 addr", 64'(instr_addr), 64'(8'h00));
    repeat (2) @(negedge clk);
    check("jmp cycle2 addr", 64'(instr_addr), 64'(8'h05));
    repeat (2) @(negedge clk);
    check("halt state", 64'({busy, halted, instr_addr}), 64'({1'b0, 1'b1, 8'h05}));
    nw = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wr_en || busy || !halted) nw++;
    end
    check("halted hold", 64'(nw), 64'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart fetch", 64'({busy, halted, instr_addr}), 64'({1'b1, 1'b0, 8'h00}));

    // ---- asynchronous reset in the middle of WB ----
    enter_reset();
    rom[0] = 16'h1050;
    leave_reset_and_start();
    repeat (3) @(negedge clk);
    check("pre-reset in WB", 64'({wr_en, add_wr, dado_wr}), 64'({1'b1, 3'd0, 8'hE3}));
    rst = 1'b0;
    #1;
    check("reset mid-WB outputs", 64'(sample()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1'b1;
    nw = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy || halted || wr_en || instr_addr != 8'h00) nw++;
    end
    check("idle after reset", 64'(nw), 64'(0));

    // ---- pc wrap 255 -> 0 ----
    enter_reset();
    rom[0]   = 16'h80FF;
    rom[255] = 16'h0000;
    leave_reset_and_start();
    repeat (2) @(negedge clk);
    check("wrap at 255", 64'(instr_addr), 64'(8'hFF));
    repeat (2) @(negedge clk);
    check("wrap to 0", 64'({busy, instr_addr}), 64'({1'b1, 8'h00}));

    // ---- random programs against the instruction-level model ----
    for (int run = 0; run < 3; run++) begin
      int r;
      logic [15:0] w;
      enter_reset();
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        r = $urandom_range(0, 99);
        if (r < 50)      w[15:12] = 4'($urandom_range(1, 6));
        else if (r < 65) w[15:12] = 4'd7;
        else if (r < 77) w[15:12] = 4'd9;
        else if (r < 83) w[15:12] = 4'd8;
        else if (r < 90) w[15:12] = 4'd0;
        else if (r < 99) w[15:12] = 4'($urandom_range(10, 14));
        else             w[15:12] = 4'd15;
        rom[i] = w;
      end
      build_trace(500);
      leave_reset_and_start();
      for (int c = 0; c < 500; c++) begin
        act = sample();
        check($sformatf("rand%0d cycle %0d", run, c), 64'(act), 64'(exp_q[c]));
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_execucao.md
# controle_execucao

Multi-cycle control unit for the 8-bit nano processor. It fetches 16-bit instructions from a synchronous instruction ROM, decodes them, and drives the register bank read/write ports and the ULA (ALU) operation code. It sequences each instruction through FETCH/DECODE/EXEC/WB so that the bank's one-cycle registered read latency is respected and no read/write hazard can occur.

## Interface
- PC_W, 8, program counter width (1..8); ROM depth 2^PC_W
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  level-sampled; begins execution from IDLE, restarts from HALTED
- instr_addr  out  PC_W  ROM address (= pc)
- instr_data  in  16  ROM data, valid one cycle after instr_addr
- add_r1, add_r2  out  3  bank read addresses
- dado_r1, dado_r2  in  8  bank read data (registered inside bank)
- wr_en  out  1  bank write enable
- add_wr  out  3  bank write address
- dado_wr  out  8  bank write data
- ula_op  out  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A
- ula_res  in  8  combinational ALU result of dado_r1 op dado_r2
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALTED

## Operation
- Format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm.
- Opcodes: 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (rd <= rs1 op rs2); 6 MOV (rd <= rs1, PASS_A); 7 LDI (rd <= imm); 8 JMP (pc <= imm); 9 BZ (if R[rd]==0, pc <= imm); 15 HALT; 10..14 execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- IDLE: start=1 -> FETCH. HALTED: start=1 -> FETCH with pc=0; otherwise hold.
- FETCH: instr_addr=pc -> DECODE.
- DECODE: IR <= instr_data. add_r1/add_r2 are driven combinationally from instr_data (add_r1 = rd field for BZ, rs1 otherwise; add_r2 = rs2). pc <= pc+1, except JMP (pc <= imm[PC_W-1:0]). Next state: ALU/MOV/BZ -> EXEC; LDI -> WB; JMP/NOP/undefined -> FETCH; HALT -> HALTED, with pc not incremented.
- EXEC: addresses are held from IR; dado_r* are valid. ula_op is driven from the opcode, and res <= ula_res. BZ: if dado_r1==8'h00, pc <= imm, then -> FETCH. ALU/MOV -> WB.
- WB: wr_en=1, add_wr=IR.rd, dado_wr = res (ALU/MOV) or imm (LDI) -> FETCH.
- Arithmetic is 8-bit modulo; no flags or carry. pc wraps from 2^PC_W-1 to 0.
- start is ignored while busy.

## Timing
- Reset (asynchronous, any state including mid-WB): state=IDLE, pc=0, IR=0, res=0. All outputs are 0: instr_addr, add_r1, add_r2, wr_en, add_wr, dado_wr, ula_op, busy, halted.
- In states other than DECODE/EXEC, read addresses and ula_op are 0. wr_en is high only in WB, for exactly one cycle.
- Latency (cycles from FETCH entry): ALU/MOV 4; LDI 3; BZ 3; JMP/NOP 2; HALT 2, then halted=1.
- A write lands at the end of WB. The following instruction's read is sampled at the end of its DECODE, 2 cycles later, so back-to-back dependencies need no forwarding.
- From IDLE, start=1 puts FETCH with instr_addr=0 in the next cycle.

## Structure
- Shared package nano_pkg holds: opcode localparams, ULA op codes (shared with the ULA), state encoding, and instruction field bit positions.
- One combinational sub-module, decodificador_instr. Input: opcode. Outputs: ula_op, is_alu, is_ldi, is_jmp, is_bz, is_halt, writes_rd.
- Target size: ~200 lines of RTL.

## Test plan
Bench uses the register bank at reset contents R[n]=8'hF0+n and a ROM model with one-cycle read latency.
- ROM[0]=16'h1050 (ADD r0,r1,r2), start pulse -> 4th cycle after FETCH has wr_en=1, add_wr=0, dado_wr=8'hE3; pc=1.
- ROM[0]=16'h2838 (SUB r4,r0,r7) -> WB writes R4=8'hF9 (wrap). ula_op=1 during EXEC.
- ROM[0]=16'h7600 (LDI r3,0), ROM[1]=16'h9610 (BZ r3,0x10) -> R3=0; next FETCH has instr_addr=8'h10. With a nonzero imm in the LDI, the branch is not taken and instr_addr=2.
- ROM[0]=16'h8005 (JMP 5), ROM[5]=16'hF000 (HALT) -> instr_addr 0, then 5; halted=1, busy=0, and state holds with no wr_en. Then start=1 -> FETCH at pc=0.
- rst low during WB of an ADD -> outputs immediately 0 and no write occurs. After rst rises, the block stays in IDLE until start.
- ROM at 255 with PC_W=8 holding NOP -> next instr_addr=0 (wrap); opcode 16'hA000 behaves as NOP (2 cycles, no write).
